// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared constants and types for the data_memory block.
//
// Holds the line geometry (width, depth, where the line index sits in a
// byte address), the default access latency and the controller state type.
package dmem_pkg;

  localparam int DMEM_DATA_W  = 256;
  localparam int DMEM_DEPTH   = 512;
  localparam int DMEM_IDX_LSB = 5;
  localparam int DMEM_IDX_MSB = 13;
  localparam int DMEM_LATENCY = 10;

  typedef enum logic {
    DMEM_IDLE,
    DMEM_WAIT
  } dmem_state_t;

endpackage

// File: rtl/data_memory.sv
// data_memory -- main data memory behind the data cache.
//
// 512 lines x 256 bits, whole-line accesses only. One request is served at a
// time; completion is a single-cycle ack_o pulse LATENCY edges after the
// request is accepted.
//
// Ports:
//   clk_i     clock, all state changes on the rising edge
//   rst_i     synchronous active-high reset (controller only; contents persist)
//   addr_i    byte address, line index = addr_i[13:5]
//   data_i    write line data
//   enable_i  request valid, held by the requester until ack
//   write_i   1 = write, 0 = read
//   ack_o     one-cycle completion pulse
//   data_o    read line data while ack_o=1, zero otherwise
//
// Optional build macro:
//   DMEM_TRACE_EN  prints one simulation trace line per completed access.
//                  Behaviour is identical with or without it.
module data_memory
  import dmem_pkg::*;
#(
  parameter int LATENCY = DMEM_LATENCY,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int DATA_W  = DMEM_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam int IDX_W = DMEM_IDX_MSB - DMEM_IDX_LSB + 1;

  // Line storage; never cleared, so benches can preload and inspect it.
  logic [DATA_W-1:0] memory [0:DEPTH-1];

  dmem_state_t      state;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] idx;

  assign idx = addr_i[DMEM_IDX_MSB:DMEM_IDX_LSB];

  // Offset-within-line and high address bits play no part in addressing;
  // addresses beyond 16 KB simply wrap.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:DMEM_IDX_MSB+1], addr_i[DMEM_IDX_LSB-1:0]};

  assign ack_o  = (state == DMEM_WAIT) && (count == CNT_LAST);
  // For a write this shows the pre-write line, since the store lands at
  // the ack edge itself.
  assign data_o = ack_o ? memory[idx] : '0;

  // Request sequencing: accept in IDLE, count out the latency in WAIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= DMEM_IDLE;
      count <= '0;
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (enable_i) begin
            state <= DMEM_WAIT;
            count <= '0;
          end
        end
        DMEM_WAIT: begin
          if (count == CNT_LAST) begin
            state <= DMEM_IDLE;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
          state <= DMEM_IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Line store at the ack edge. A reset landing on that same edge aborts
  // the request, so the write is suppressed as well.
  always_ff @(posedge clk_i) begin
    if (!rst_i && ack_o && write_i) begin
      memory[idx] <= data_i;
    end
`ifdef DMEM_TRACE_EN
    if (!rst_i && ack_o) begin
      $display("%0t dmem %s %h %h", $time, write_i ? "W" : "R",
               {addr_i[31:DMEM_IDX_LSB], 5'b0}, write_i ? data_i : memory[idx]);
    end
`endif
  end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory -- scoreboard bench for data_memory.
//
// A driver issues whole-line requests and pushes the expected completion
// (cycle of the ack and the line data) into a queue, computed from an array
// model of the memory contents. A monitor pops and compares on every ack and
// also checks that data_o is zero and no stray ack appears in other cycles.
module tb_data_memory;
  import dmem_pkg::*;

  localparam int LAT = 10;

  logic         clk;
  logic         rst;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         enable;
  logic         write;
  logic         ack;
  logic [255:0] rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           cyc;
    logic [255:0] data;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] model [512];

  data_memory #(.LATENCY(LAT), .DEPTH(512), .DATA_W(256)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (addr),
    .data_i  (wdata),
    .enable_i(enable),
    .write_i (write),
    .ack_o   (ack),
    .data_o  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ack high at cycle %0d, required no ack", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rdata !== e.data) begin
          errors++;
          $display("FAIL ack_data: got %h required %h", rdata, e.data);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL ack_cycle: got %0d required %0d", cyc, e.cyc);
        end
      end
    end else begin
      checks++;
      if (rdata !== '0) begin
        errors++;
        $display("FAIL data_idle: got %h required 0 at cycle %0d", rdata, cyc);
      end
    end
  end

  // Issue one request at the current falling edge and wait for its ack.
  // Returns at the falling edge after the ack edge, with enable still high
  // unless dropped, so a following call is a back-to-back request.
  task automatic do_req(input logic [31:0] a, input logic wr, input logic [255:0] d,
                        input bit drop);
    int  idx;
    bit  got;
    idx    = int'(a[13:5]);
    addr   = a;
    wdata  = d;
    write  = wr;
    enable = 1'b1;
    exp_q.push_back('{cyc + LAT, model[idx]});
    if (wr) model[idx] = d;
    got = 1'b0;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(negedge clk);
      if (drop && k == 3) enable = 1'b0;
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout: no ack for addr %h within %0d cycles", a, LAT + 4);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_line(input string name, input int idx, input logic [255:0] req);
    checks++;
    if (dut.memory[idx] !== req) begin
      errors++;
      $display("FAIL %s: memory[%0d] got %h required %h", name, idx, dut.memory[idx], req);
    end
  endtask

  initial begin
    logic [255:0] v0, v17, v32, ecfa, d;
    logic [31:0]  a;
    v0   = 256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    ecfa = {16{16'hECFA}};
    for (int k = 0; k < 16; k++) begin
      v17[255 - 16*k -: 16] = 16'(k * 16'h0110);
      v32[255 - 16*k -: 16] = 16'(k * 16'h1001);
    end

    rst    = 1'b1;
    enable = 1'b0;
    write  = 1'b0;
    addr   = '0;
    wdata  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (ack !== 1'b0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_state: ack %b data %h required ack 0 data 0", ack, rdata);
    end
    rst = 1'b0;
    @(negedge clk);

    // Fill every line through the port (random ignored address bits).
    for (int i = 0; i < 512; i++) begin
      d = (i == 0) ? v0 : (i == 17) ? v17 : (i == 32) ? v32 : rand256();
      a = {18'($urandom), 9'(i), 5'($urandom)};
      do_req(a, 1'b1, d, 1'b0);
    end
    idle(2);
    check_line("fill_line0", 0, v0);

    // Directed cases.
    do_req(32'h0000_0000, 1'b0, '0, 1'b0);
    idle(3);
    do_req(32'h0000_0240, 1'b1, ecfa, 1'b0);
    check_line("write_line18", 18, ecfa);
    check_line("keep_line17", 17, v17);
    check_line("keep_line19", 19, model[19]);
    idle(1);
    do_req(32'h0000_023F, 1'b0, '0, 1'b0);
    do_req(32'h0000_4000, 1'b0, '0, 1'b0);
    idle(2);
    // Back-to-back pair: enable stays high across the first ack.
    do_req(32'h0000_0000, 1'b0, '0, 1'b0);
    do_req(32'h0000_0020, 1'b0, '0, 1'b0);
    idle(2);

    // Reset five edges into a write: no ack, no store.
    addr   = 32'h0000_0400;
    wdata  = rand256();
    write  = 1'b1;
    enable = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check_line("abort_line32", 32, v32);
    do_req(32'h0000_0400, 1'b0, '0, 1'b0);
    idle(1);

    // Enable dropped during WAIT still completes.
    do_req(32'h0000_0000, 1'b0, '0, 1'b1);
    idle(1);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      do_req(a, 1'($urandom_range(0, 1)), rand256(), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(LAT + 3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect: %0d outstanding, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
